// File: rtl/cu_pkg.sv
// Shared types and constants for the row-fetch responder.
package cu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rowfetch_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [SKID_CNT_W-1:0] SKID_FULL = SKID_CNT_W'(SKID_DEPTH);

endpackage

// File: rtl/row_fetch_responder_if.sv
// Command, BRAM read port and pixel stream of the row-fetch responder.
// The master modport is the responder's view; slave is its environment.
interface row_fetch_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int COL_WIDTH  = $clog2(IMG_WIDTH)
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] row_base_addr;
  logic                  busy;
  logic                  done;
  logic                  bram_rd_en;
  logic [ADDR_WIDTH-1:0] bram_rd_addr;
  logic [DATA_WIDTH-1:0] bram_rd_data;
  logic                  pix_valid;
  logic [DATA_WIDTH-1:0] pix_data;
  logic [COL_WIDTH-1:0]  pix_col;
  logic                  pix_last;
  logic                  pix_ready;

  modport master (
    input  start, row_base_addr, bram_rd_data, pix_ready,
    output busy, done, bram_rd_en, bram_rd_addr,
           pix_valid, pix_data, pix_col, pix_last
  );

  modport slave (
    output start, row_base_addr, bram_rd_data, pix_ready,
    input  busy, done, bram_rd_en, bram_rd_addr,
           pix_valid, pix_data, pix_col, pix_last
  );
endinterface

// File: rtl/skid_fifo2.sv
// Two-entry register FIFO; the head entry is always a register so the
// consumer sees a clean value. A push into a full FIFO is only honoured
// when a pop happens in the same cycle.
module skid_fifo2
  import cu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [SKID_CNT_W-1:0] count,
  output logic [WIDTH-1:0]      head
);

  logic [WIDTH-1:0] entry1;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != SKID_FULL) || do_pop);

  // Shift the second entry into the head on pop, land new data behind it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      head   <= '0;
      entry1 <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count == '0) head <= din;
          else             entry1 <= din;
          count <= count + SKID_CNT_W'(1);
        end
        2'b01: begin
          head  <= entry1;
          count <= count - SKID_CNT_W'(1);
        end
        2'b11: begin
          if (count == SKID_CNT_W'(1)) begin
            head <= din;
          end else begin
            head   <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/row_fetch_responder.sv
// Fetches one image row from a 1-cycle-latency BRAM and streams it out
// over valid/ready, pulsing done after the last pixel is accepted.
// Reads are credit-limited so the two-entry skid buffer cannot overflow.
module row_fetch_responder
  import cu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int COL_WIDTH  = $clog2(IMG_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  row_fetch_responder_if.master  bus
);

  localparam int ENTRY_W = DATA_WIDTH + COL_WIDTH + 1;
  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(IMG_WIDTH - 1);

  rowfetch_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [COL_WIDTH-1:0]  issue_col;
  logic [COL_WIDTH-1:0]  out_col;
  logic                  inflight;
  logic                  rd_en;
  logic                  credit;
  logic [2:0]            occupancy;
  logic                  skid_pop;
  logic [SKID_CNT_W-1:0] skid_count;
  logic [ENTRY_W-1:0]    skid_head;
  logic [ENTRY_W-1:0]    push_entry;
  logic                  pix_handshake;
  logic                  last_accepted;
  logic                  start_accept;

  assign start_accept  = (state_q == IDLE) && bus.start;
  assign pix_handshake = bus.pix_valid && bus.pix_ready;
  assign skid_pop      = (skid_count != '0) && (!bus.pix_valid || bus.pix_ready);
  assign occupancy     = 3'(skid_count) + 3'(inflight) - 3'(skid_pop);
  assign credit        = occupancy < 3'(SKID_DEPTH);
  assign last_accepted = pix_handshake && bus.pix_last && (skid_count == '0) && !inflight;
  assign push_entry    = {bus.bram_rd_data, out_col, out_col == LAST_COL};

  assign bus.bram_rd_en   = rd_en;
  assign bus.bram_rd_addr = rd_en ? base_addr + ADDR_WIDTH'(issue_col) : '0;
  assign bus.busy         = (state_q == FETCH) || (state_q == DRAIN);
  assign bus.done         = (state_q == DONE);

  // Sequencing: issue reads while credit allows, drain, then a done pulse.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = FETCH;
      end
      FETCH: begin
        rd_en = credit;
        if (credit && (issue_col == LAST_COL)) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_accepted) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Row base capture, read/column counters and the one-cycle read tracker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_addr <= '0;
      issue_col <= '0;
      out_col   <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (start_accept) begin
        base_addr <= bus.row_base_addr;
        issue_col <= '0;
        out_col   <= '0;
      end else begin
        if (rd_en)    issue_col <= issue_col + COL_WIDTH'(1);
        if (inflight) out_col   <= out_col + COL_WIDTH'(1);
      end
    end
  end

  skid_fifo2 #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .din   (push_entry),
    .pop   (skid_pop),
    .count (skid_count),
    .head  (skid_head)
  );

  // Output register: reload from the buffer head when empty or accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.pix_valid <= 1'b0;
      bus.pix_data  <= '0;
      bus.pix_col   <= '0;
      bus.pix_last  <= 1'b0;
    end else if (skid_pop) begin
      bus.pix_valid <= 1'b1;
      {bus.pix_data, bus.pix_col, bus.pix_last} <= skid_head;
    end else if (pix_handshake) begin
      bus.pix_valid <= 1'b0;
      bus.pix_data  <= '0;
      bus.pix_col   <= '0;
      bus.pix_last  <= 1'b0;
    end
  end

endmodule
